ram_march_bist: RTL and testbench
=================================

// Module: ram_march_bist
// PURPOSE
//  March C- built-in self-test controller that drives the client side of a 32x4 single-port RAM.
//  The RAM has registered read data: dout is valid one edge after addr, and a write also updates dout.
//  The controller sits between the system top and the RAM; the bench and top mux its ram_* pins onto the RAM.
//  It reports pass/fail plus the address, element and data of the first miscompare.
// PARAMETERS
//  ADDR_W  5  RAM address width; DEPTH = 2**ADDR_W words
//  DATA_W  4  RAM word width; backgrounds are all-0 and all-1
// PORTS
//  clk        in   1       single clock, all state changes on posedge
//  reset      in   1       synchronous, active-high
//  start      in   1       level; sampled only in IDLE or DONE
//  busy       out  1       high from the edge after start is accepted until DONE
//  done       out  1       level; high in DONE until the next accepted start or reset
//  pass       out  1       valid while done=1; 1 = no miscompare
//  fail_addr  out  ADDR_W  address of the first miscompare; 0 if pass
//  fail_elem  out  3       march element 0..5 of the first miscompare; 0 if pass
//  fail_data  out  DATA_W  RAM data read at the first miscompare; 0 if pass
//  ram_addr   out  ADDR_W  to RAM addr
//  ram_din    out  DATA_W  to RAM din
//  ram_wren   out  1       to RAM wren
//  ram_dout   in   DATA_W  from RAM dout; registered, 1-cycle read latency
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, pass, fail_*, ram_addr, ram_din and ram_wren are all 0.
//    A reset mid-test aborts immediately; RAM contents are left as they are.
//  - The ram_* outputs are Moore-decoded from the state, the address counter and the element counter.
//  - Elements:
//      E0 up   W0
//      E1 up   R0 W1
//      E2 up   R1 W0
//      E3 down R0 W1
//      E4 down R1 W0
//      E5 down R0
//    up = address 0..DEPTH-1; down = address DEPTH-1..0.
//  - States:
//      IDLE  -> W0      on start; address counter = 0, element = 0
//      W0    -> wren=1, din=0, one address per cycle; after DEPTH-1, go to RD with element 1
//      RD    -> wren=0, addr=cur (read issued); always go to WR
//      WR    -> compare ram_dout against the expected background (~din); then wren=1, addr=cur, din=new background.
//               The write happens even on a miscompare.
//               On a miscompare go to DONE with pass=0.
//               At the last address of the element: element+1 and reload the counter for the next direction.
//               After element 4, go to RF.
//               Otherwise step the address and go to RD.
//      RF    -> wren=0 read of E5; go to CK
//      CK    -> compare against 0; on a miscompare go to DONE with pass=0.
//               At address 0 go to DONE with pass=1; otherwise decrement the address and go to RF.
//      DONE  -> hold the outputs; start (level) re-enters W0 and clears done, pass and fail_*.
//  - Timing: if start is sampled at edge E0, done rises after edge E0+352
//    (32 + 4*64 + 64 cycles; in general DEPTH*11).
//  - The first miscompare only is captured; the test stops there and later elements are not run.
//  - start while busy is ignored. start and reset together: reset wins.
//  - The address counter wraps modulo DEPTH, but the element change is decided on the terminal count
//    (DEPTH-1 going up, 0 going down), never on the wrap itself.
// STRUCTURE
//  - Package ram_bist_pkg:
//      state_t enum {IDLE, W0, RD, WR, RF, CK, DONE}
//      elem_t 3-bit constants E0..E5
//      function bg(elem) returning the expected and write backgrounds
//  - Sub-module bist_addr_ctr: loadable up/down ADDR_W counter with a terminal-count flag.
//  - The top-level module holds the FSM, the compare logic and the fail capture registers.
// TESTING (bench instantiates ram32D_4W with a fault-injection wrapper on dout)
//  1. Reset, then start=1 for 1 cycle, fault-free RAM
//     -> busy for 352 cycles, then done=1, pass=1, fail_addr=0, fail_elem=0.
//  2. Bit 2 of word 5 stuck at 1 -> done=1, pass=0, fail_addr=5, fail_elem=1, fail_data=4'b0100.
//  3. Bit 0 of word 31 stuck at 0 -> pass=0, fail_addr=31, fail_elem=2, fail_data=4'b1110.
//  4. Reset asserted at cycle 100 of a run -> next cycle all outputs are 0 and the state is IDLE.
//     A fresh start then passes in 352 cycles.
//  5. start held high through a whole run -> exactly one run completes, then an immediate restart from DONE;
//     done drops for the second run, and starts seen while busy have no effect.
//  6. Trace check on a fault-free run: first write to addr 0 with din=0;
//     E3 begins with ram_addr=31 and wren=0; the last access is a read of addr 0.

Source files
------------

// File: rtl/ram_march_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bist_pkg
//  Description : Shared types, march element codes and background lookup
//                for the March C- RAM BIST controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_bist_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        RF   = 3'd4,
        CK   = 3'd5,
        DONE = 3'd6
    } state_t;

    // March element index
    typedef logic [2:0] elem_t;

    localparam elem_t E0 = 3'd0;  // up   W0
    localparam elem_t E1 = 3'd1;  // up   R0 W1
    localparam elem_t E2 = 3'd2;  // up   R1 W0
    localparam elem_t E3 = 3'd3;  // down R0 W1
    localparam elem_t E4 = 3'd4;  // down R1 W0
    localparam elem_t E5 = 3'd5;  // down R0

    // Backgrounds of an element: exp_one = expected read is all-1,
    // wr_one = background written is all-1.
    typedef struct packed {
        logic exp_one;
        logic wr_one;
    } bg_t;

    function automatic bg_t bg(input elem_t e);
        bg_t b;
        b = '{exp_one: 1'b0, wr_one: 1'b0};
        case (e)
            E1:      b = '{exp_one: 1'b0, wr_one: 1'b1};
            E2:      b = '{exp_one: 1'b1, wr_one: 1'b0};
            E3:      b = '{exp_one: 1'b0, wr_one: 1'b1};
            E4:      b = '{exp_one: 1'b1, wr_one: 1'b0};
            default: b = '{exp_one: 1'b0, wr_one: 1'b0};
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_march_bist_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_bist_if
//  Description : Control/status and RAM client bus of the March C- BIST.
//                master = BIST controller side, slave = system/RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_march_bist_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    import ram_bist_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    elem_t             fail_elem;
    logic [DATA_W-1:0] fail_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        input  start, ram_dout,
        output busy, done, pass, fail_addr, fail_elem, fail_data,
               ram_addr, ram_din, ram_wren
    );

    modport slave (
        output start, ram_dout,
        input  busy, done, pass, fail_addr, fail_elem, fail_data,
               ram_addr, ram_din, ram_wren
    );

endinterface
`default_nettype wire

// File: rtl/ram_march_bist_addr_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : bist_addr_ctr
//  Description : Loadable up/down address counter with terminal-count flag.
//                Terminal count is DEPTH-1 counting up and 0 counting down;
//                the counter itself wraps modulo DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_addr_ctr #(
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              load_i,
    input  wire logic [ADDR_W-1:0] load_val_i,
    input  wire logic              en_i,
    input  wire logic              up_i,
    output logic      [ADDR_W-1:0] cnt_o,
    output logic                   tc_o
);

    localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_MAX = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Next count: load has priority over stepping
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = up_i ? (cnt_q + C_ONE) : (cnt_q - C_ONE);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = up_i ? (cnt_q == C_MAX) : (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_bist
//  Description : March C- BIST controller for a single-port RAM with a
//                registered (1-cycle) read port. Reports pass/fail and the
//                address, element and data of the first miscompare.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    ram_march_bist_if.master   bus_if
);

    localparam logic [ADDR_W-1:0] C_ADDR_MAX = {ADDR_W{1'b1}};

    // FSM and capture registers
    state_t            state_q;
    elem_t             elem_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ADDR_W-1:0] fail_addr_q;
    elem_t             fail_elem_q;
    logic [DATA_W-1:0] fail_data_q;

    // Counter interface
    logic              w_ctr_load;
    logic [ADDR_W-1:0] w_ctr_load_val;
    logic              w_ctr_en;
    logic              w_ctr_up;
    logic [ADDR_W-1:0] w_addr;
    logic              w_tc;

    // Compare path
    bg_t               w_bg;
    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_wr;
    logic              w_mis;

    // Elements 0..2 run upwards, 3..5 downwards
    assign w_ctr_up = (elem_q < E3);

    assign w_bg  = bg(elem_q);
    assign w_exp = {DATA_W{w_bg.exp_one}};
    assign w_wr  = {DATA_W{w_bg.wr_one}};
    assign w_mis = (bus_if.ram_dout != w_exp);

    bist_addr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_ctr_load),
        .load_val_i (w_ctr_load_val),
        .en_i       (w_ctr_en),
        .up_i       (w_ctr_up),
        .cnt_o      (w_addr),
        .tc_o       (w_tc)
    );

    // Address counter control: reload at element boundaries, step otherwise
    always_comb begin
        w_ctr_load     = 1'b0;
        w_ctr_load_val = '0;
        w_ctr_en       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                w_ctr_load = bus_if.start;
            end
            W0: begin
                if (w_tc) begin
                    w_ctr_load = 1'b1;
                end else begin
                    w_ctr_en = 1'b1;
                end
            end
            WR: begin
                if (!w_mis) begin
                    if (w_tc) begin
                        // Next element runs down from E3 on
                        w_ctr_load     = 1'b1;
                        w_ctr_load_val = (elem_q >= E2) ? C_ADDR_MAX : '0;
                    end else begin
                        w_ctr_en = 1'b1;
                    end
                end
            end
            CK: begin
                w_ctr_en = !w_mis && !w_tc;
            end
            default: begin
                w_ctr_load = 1'b0;
            end
        endcase
    end

    // RAM client pins are a Moore decode of state, counter and element
    always_comb begin
        bus_if.ram_addr = '0;
        bus_if.ram_din  = '0;
        bus_if.ram_wren = 1'b0;
        case (state_q)
            W0: begin
                bus_if.ram_addr = w_addr;
                bus_if.ram_wren = 1'b1;
            end
            RD, RF: begin
                bus_if.ram_addr = w_addr;
            end
            WR: begin
                bus_if.ram_addr = w_addr;
                bus_if.ram_din  = w_wr;
                bus_if.ram_wren = 1'b1;
            end
            default: begin
                bus_if.ram_wren = 1'b0;
            end
        endcase
    end

    // March sequencing, status flags and first-miscompare capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            elem_q      <= E0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= E0;
            fail_data_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus_if.start) begin
                        state_q     <= W0;
                        elem_q      <= E0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_elem_q <= E0;
                        fail_data_q <= '0;
                    end
                end
                W0: begin
                    if (w_tc) begin
                        state_q <= RD;
                        elem_q  <= E1;
                    end
                end
                RD: begin
                    state_q <= WR;
                end
                WR: begin
                    if (w_mis) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= w_addr;
                        fail_elem_q <= elem_q;
                        fail_data_q <= bus_if.ram_dout;
                    end else if (w_tc) begin
                        elem_q  <= elem_q + 3'd1;
                        state_q <= (elem_q == E4) ? RF : RD;
                    end else begin
                        state_q <= RD;
                    end
                end
                RF: begin
                    state_q <= CK;
                end
                CK: begin
                    if (w_mis) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_addr_q <= w_addr;
                        fail_elem_q <= elem_q;
                        fail_data_q <= bus_if.ram_dout;
                    end else if (w_tc) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else begin
                        state_q <= RF;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.busy      = busy_q;
    assign bus_if.done      = done_q;
    assign bus_if.pass      = pass_q;
    assign bus_if.fail_addr = fail_addr_q;
    assign bus_if.fail_elem = fail_elem_q;
    assign bus_if.fail_data = fail_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_march_bist
//  Description : Directed bench for ram_march_bist with a 32x4 registered-
//                read RAM model and a stuck-at fault wrapper on its dout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_march_bist;
    import ram_bist_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;
    localparam int RUN    = 352;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc;

    always #5 clk = ~clk;

    ram_march_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_march_bist #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus.master)
    );

    // RAM model: registered read, write also updates dout
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_raw = '0;
    logic [ADDR_W-1:0] dout_addr = '0;
    logic              fault_en = 1'b0;
    logic [ADDR_W-1:0] fault_addr = '0;
    logic [DATA_W-1:0] stuck1 = '0;
    logic [DATA_W-1:0] stuck0 = '0;

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_din;
            dout_raw          <= bus.ram_din;
        end else begin
            dout_raw <= mem[bus.ram_addr];
        end
        dout_addr <= bus.ram_addr;
    end

    assign bus.ram_dout = (fault_en && dout_addr == fault_addr)
                          ? ((dout_raw & ~stuck0) | stuck1) : dout_raw;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one accepted edge
    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Wait for done with a cycle budget; cyc counts edges since acceptance
    task automatic wait_done(input string tag);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            tick();
            cyc++;
        end
        check({tag, "_timeout"}, 32'(bus.done), 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;

        // 1. reset state
        tick(); tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_pass", 32'(bus.pass), 0);
        check("rst_wren", 32'(bus.ram_wren), 0);
        check("rst_addr", 32'(bus.ram_addr), 0);
        reset = 1'b0;
        tick();

        // 1 + 6. fault-free run with trace checks
        pulse_start();
        check("t1_busy0", 32'(bus.busy), 1);
        check("t6_first_wren", 32'(bus.ram_wren), 1);
        check("t6_first_addr", 32'(bus.ram_addr), 0);
        check("t6_first_din", 32'(bus.ram_din), 0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            tick();
            cyc++;
            if (cyc == 159) begin
                check("t6_e2_last_addr", 32'(bus.ram_addr), 31);
                check("t6_e2_last_din", 32'(bus.ram_din), 0);
                check("t6_e2_last_wren", 32'(bus.ram_wren), 1);
            end
            if (cyc == 160) begin
                check("t6_e3_addr", 32'(bus.ram_addr), 31);
                check("t6_e3_wren", 32'(bus.ram_wren), 0);
            end
            if (cyc == 350) begin
                check("t6_last_addr", 32'(bus.ram_addr), 0);
                check("t6_last_wren", 32'(bus.ram_wren), 0);
            end
            if (cyc < RUN && bus.busy !== 1'b1) begin
                check("t1_busy_run", 32'(bus.busy), 1);
            end
        end
        check("t1_cycles", 32'(cyc), RUN);
        check("t1_done", 32'(bus.done), 1);
        check("t1_busy_end", 32'(bus.busy), 0);
        check("t1_pass", 32'(bus.pass), 1);
        check("t1_faddr", 32'(bus.fail_addr), 0);
        check("t1_felem", 32'(bus.fail_elem), 0);
        check("t1_fdata", 32'(bus.fail_data), 0);

        // 2. word 5 bit 2 stuck at 1 -> caught in E1
        fault_en = 1'b1; fault_addr = 5'd5; stuck1 = 4'b0100; stuck0 = 4'b0000;
        pulse_start();
        check("t2_done_clr", 32'(bus.done), 0);
        wait_done("t2");
        check("t2_cycles", 32'(cyc), 44);
        check("t2_pass", 32'(bus.pass), 0);
        check("t2_faddr", 32'(bus.fail_addr), 5);
        check("t2_felem", 32'(bus.fail_elem), 1);
        check("t2_fdata", 32'(bus.fail_data), 32'h4);
        check("t2_busy", 32'(bus.busy), 0);

        // 3. word 31 bit 0 stuck at 0 -> caught in E2
        fault_addr = 5'd31; stuck1 = 4'b0000; stuck0 = 4'b0001;
        pulse_start();
        check("t3_faddr_clr", 32'(bus.fail_addr), 0);
        check("t3_felem_clr", 32'(bus.fail_elem), 0);
        wait_done("t3");
        check("t3_cycles", 32'(cyc), 160);
        check("t3_pass", 32'(bus.pass), 0);
        check("t3_faddr", 32'(bus.fail_addr), 31);
        check("t3_felem", 32'(bus.fail_elem), 2);
        check("t3_fdata", 32'(bus.fail_data), 32'hE);

        // 4. reset mid-run (with start asserted too), then a fresh passing run
        fault_en = 1'b0;
        pulse_start();
        repeat (99) tick();
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_done", 32'(bus.done), 0);
        check("t4_pass", 32'(bus.pass), 0);
        check("t4_faddr", 32'(bus.fail_addr), 0);
        check("t4_wren", 32'(bus.ram_wren), 0);
        check("t4_addr", 32'(bus.ram_addr), 0);
        check("t4_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        bus.start = 1'b0;
        tick();
        pulse_start();
        wait_done("t4");
        check("t4_cycles", 32'(cyc), RUN);
        check("t4_pass_after", 32'(bus.pass), 1);

        // 5. start held high: one full run, then immediate restart from DONE
        bus.start = 1'b1;
        tick();
        wait_done("t5a");
        check("t5_cycles_a", 32'(cyc), RUN);
        check("t5_pass_a", 32'(bus.pass), 1);
        tick();
        check("t5_done_drop", 32'(bus.done), 0);
        check("t5_busy_restart", 32'(bus.busy), 1);
        bus.start = 1'b0;
        wait_done("t5b");
        check("t5_cycles_b", 32'(cyc), RUN);
        check("t5_pass_b", 32'(bus.pass), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
